// File: rtl/spike_pkg.sv
// Shared types, widths and the accumulator saturation helper for the spike encoder.
package spike_pkg;
  localparam int SPK_NCH   = 4;
  localparam int SPK_DW    = 12;
  localparam int SPK_AW    = 20;
  localparam int SPK_RW    = 4;
  localparam int SPK_TSW   = 16;
  localparam int SPK_DEPTH = 8;
  localparam int SPK_WW    = SPK_AW + 16;

  localparam logic signed [SPK_AW-1:0] ACC_MAX = {1'b0, {(SPK_AW-1){1'b1}}};
  localparam logic signed [SPK_AW-1:0] ACC_MIN = {1'b1, {(SPK_AW-1){1'b0}}};

  typedef enum logic {
    RST_ZERO = 1'b0,
    RST_SUB  = 1'b1
  } reset_mode_e;

  typedef struct packed {
    logic [SPK_NCH-1:0] mask;
    logic [SPK_TSW-1:0] stamp;
  } spike_event_t;

  // Clamp a wide signed sum into the signed accumulator range.
  function automatic logic signed [SPK_AW-1:0] sat_acc(input logic signed [SPK_WW-1:0] wide);
    logic signed [SPK_WW-1:0] wide_max;
    logic signed [SPK_WW-1:0] wide_min;
    wide_max = {{(SPK_WW-SPK_AW){1'b0}}, ACC_MAX};
    wide_min = {{(SPK_WW-SPK_AW){1'b1}}, ACC_MIN};
    if (wide > wide_max) begin
      return ACC_MAX;
    end else if (wide < wide_min) begin
      return ACC_MIN;
    end else begin
      return wide[SPK_AW-1:0];
    end
  endfunction
endpackage

// File: rtl/spike_encoder_array_fifo.sv
// Spike event FIFO: combinational head, write at clock edge, push accepted on full when popping.
module spike_event_fifo
  import spike_pkg::*;
#(
  parameter int  DEPTH     = SPK_DEPTH,
  parameter type payload_t = spike_event_t
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  payload_t din,
  input  logic     pop,
  output payload_t dout,
  output logic     full,
  output logic     empty
);
  localparam int PW = $clog2(DEPTH);

  payload_t       mem_q [DEPTH];
  logic [PW:0]    wr_q, wr_d;
  logic [PW:0]    rd_q, rd_d;
  logic           do_push;
  logic           do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign do_pop  = pop & ~empty;
  // When full, the slot being written is the one being read out this cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_q[PW-1:0]];

  always_comb begin
    wr_d = wr_q + (PW+1)'(do_push);
    rd_d = rd_q + (PW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q[PW-1:0]] <= din;
    end
  end
endmodule

// File: rtl/spike_encoder_array.sv
// Multi-channel integrate-and-fire spike encoder with timestamped event FIFO.
module spike_encoder_array
  import spike_pkg::*;
#(
  parameter int NCH   = SPK_NCH,
  parameter int DW    = SPK_DW,
  parameter int AW    = SPK_AW,
  parameter int RW    = SPK_RW,
  parameter int TSW   = SPK_TSW,
  parameter int DEPTH = SPK_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              samp_valid,
  input  logic [NCH*DW-1:0] samp_data,
  input  logic [AW-2:0]     thresh,
  input  logic [3:0]        gain_shift,
  input  logic [3:0]        leak_shift,
  input  logic              reset_mode,
  input  logic [RW-1:0]     refrac_cycles,
  output logic [NCH-1:0]    spike_vec,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [NCH-1:0]    ev_mask,
  output logic [TSW-1:0]    ev_time,
  output logic              overflow,
  input  logic              ovf_clr
);
  localparam int WW = AW + 16;

  logic           accept;
  logic [NCH-1:0] fire;
  logic [NCH-1:0] spike_vec_q, spike_vec_d;
  logic [TSW-1:0] ts_q, ts_d;
  logic           overflow_q, overflow_d;
  logic           ev_push, ev_pop, drop;
  logic           fifo_full, fifo_empty;
  spike_event_t   ev_in, ev_head;

  assign accept = samp_valid & enable;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic signed [DW-1:0] smp;
    logic signed [WW-1:0] x_w, acc_w, leak_w, sum_w;
    logic signed [AW-1:0] acc_n;
    logic signed [AW-1:0] acc_q, acc_d;
    logic [RW-1:0]        refrac_q, refrac_d;
    logic                 fire_c;

    assign smp = samp_data[c*DW +: DW];

    always_comb begin
      x_w    = {{(WW-DW){smp[DW-1]}}, smp};
      x_w    = x_w <<< gain_shift;
      acc_w  = {{(WW-AW){acc_q[AW-1]}}, acc_q};
      leak_w = '0;
      if (leak_shift != 4'd0) begin
        leak_w = acc_w >>> leak_shift;
      end
      sum_w    = acc_w - leak_w + x_w;
      acc_n    = sat_acc(sum_w);
      fire_c   = 1'b0;
      acc_d    = acc_q;
      refrac_d = refrac_q;
      if (accept) begin
        if (refrac_q != '0) begin
          refrac_d = refrac_q - RW'(1);
          acc_d    = '0;
        // One extra bit keeps the signed/unsigned threshold compare exact.
        end else if ($signed({acc_n[AW-1], acc_n}) > $signed({2'b00, thresh})) begin
          fire_c   = 1'b1;
          refrac_d = refrac_cycles;
          acc_d    = (reset_mode_e'(reset_mode) == RST_SUB) ?
                     (acc_n - $signed({1'b0, thresh})) : '0;
        end else begin
          acc_d = acc_n;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_q    <= '0;
        refrac_q <= '0;
      end else begin
        acc_q    <= acc_d;
        refrac_q <= refrac_d;
      end
    end

    assign fire[c] = fire_c;
  end

  assign ev_push     = accept & (|fire);
  assign ev_pop      = ev_valid & ev_ready;
  assign drop        = ev_push & fifo_full & ~ev_pop;
  assign ev_in.mask  = fire;
  assign ev_in.stamp = ts_q;

  always_comb begin
    spike_vec_d = accept ? fire : '0;
    ts_d        = accept ? ts_q + TSW'(1) : ts_q;
    overflow_d  = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_vec_q <= '0;
      ts_q        <= '0;
      overflow_q  <= 1'b0;
    end else begin
      spike_vec_q <= spike_vec_d;
      ts_q        <= ts_d;
      overflow_q  <= overflow_d;
    end
  end

  spike_event_fifo #(
    .DEPTH     (DEPTH),
    .payload_t (spike_event_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ev_push),
    .din   (ev_in),
    .pop   (ev_pop),
    .dout  (ev_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign spike_vec = spike_vec_q;
  assign overflow  = overflow_q;
  assign ev_valid  = ~fifo_empty;
  assign ev_mask   = ev_valid ? ev_head.mask  : '0;
  assign ev_time   = ev_valid ? ev_head.stamp : '0;
endmodule

// File: tb/tb_spike_encoder_array.sv
// Randomized and directed bench for spike_encoder_array against an arithmetic reference model.
module tb_spike_encoder_array;
  localparam int NCH   = 4;
  localparam int DW    = 12;
  localparam int AW    = 20;
  localparam int RW    = 4;
  localparam int TSW   = 16;
  localparam int DEPTH = 8;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic              samp_valid;
  logic [NCH*DW-1:0] samp_data;
  logic [AW-2:0]     thresh;
  logic [3:0]        gain_shift;
  logic [3:0]        leak_shift;
  logic              reset_mode;
  logic [RW-1:0]     refrac_cycles;
  logic [NCH-1:0]    spike_vec;
  logic              ev_valid;
  logic              ev_ready;
  logic [NCH-1:0]    ev_mask;
  logic [TSW-1:0]    ev_time;
  logic              overflow;
  logic              ovf_clr;

  spike_encoder_array dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .samp_valid    (samp_valid),
    .samp_data     (samp_data),
    .thresh        (thresh),
    .gain_shift    (gain_shift),
    .leak_shift    (leak_shift),
    .reset_mode    (reset_mode),
    .refrac_cycles (refrac_cycles),
    .spike_vec     (spike_vec),
    .ev_valid      (ev_valid),
    .ev_ready      (ev_ready),
    .ev_mask       (ev_mask),
    .ev_time       (ev_time),
    .overflow      (overflow),
    .ovf_clr       (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  longint m_acc [NCH];
  int     m_ref [NCH];
  int     m_ts;
  int     m_q_mask [$];
  int     m_q_time [$];
  int     m_ovf;
  int     m_spike;
  int     smp [NCH];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint floor_div_pow2(input longint v, input int k);
    longint d;
    d = longint'(1) << k;
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_acc[c] = 0;
      m_ref[c] = 0;
    end
    m_ts = 0;
    m_q_mask.delete();
    m_q_time.delete();
    m_ovf   = 0;
    m_spike = 0;
  endtask

  task automatic model_step();
    bit     accepted;
    bit     pop;
    bit     drop;
    int     fires;
    longint a, lim;
    accepted = samp_valid && enable;
    pop      = (m_q_mask.size() > 0) && ev_ready;
    fires    = 0;
    drop     = 0;
    lim      = longint'(1) << (AW - 1);
    if (accepted) begin
      for (int c = 0; c < NCH; c++) begin
        if (m_ref[c] != 0) begin
          m_ref[c]--;
          m_acc[c] = 0;
        end else begin
          a = m_acc[c] + longint'(smp[c]) * (longint'(1) << gain_shift);
          if (leak_shift != 0) a = a - floor_div_pow2(m_acc[c], int'(leak_shift));
          if (a > lim - 1) a = lim - 1;
          if (a < -lim) a = -lim;
          if (a > longint'(thresh)) begin
            fires |= (1 << c);
            m_acc[c] = reset_mode ? a - longint'(thresh) : 0;
            m_ref[c] = int'(refrac_cycles);
          end else begin
            m_acc[c] = a;
          end
        end
      end
    end
    m_spike = fires;
    if (pop) begin
      void'(m_q_mask.pop_front());
      void'(m_q_time.pop_front());
    end
    if (fires != 0) begin
      if (m_q_mask.size() < DEPTH) begin
        m_q_mask.push_back(fires);
        m_q_time.push_back(m_ts);
      end else begin
        drop = 1;
      end
    end
    if (accepted) m_ts = (m_ts + 1) % (1 << TSW);
    if (drop) m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
  endtask

  task automatic check_outputs();
    bit have;
    have = m_q_mask.size() > 0;
    chk("spike_vec", 64'(spike_vec), 64'(m_spike));
    chk("ev_valid", 64'(ev_valid), 64'(have));
    chk("ev_mask", 64'(ev_mask), have ? 64'(m_q_mask[0]) : 64'd0);
    chk("ev_time", 64'(ev_time), have ? 64'(m_q_time[0]) : 64'd0);
    chk("overflow", 64'(overflow), 64'(m_ovf));
  endtask

  task automatic drive_samples();
    logic [DW-1:0] s;
    for (int c = 0; c < NCH; c++) begin
      s = DW'(smp[c]);
      samp_data[c*DW +: DW] = s;
    end
  endtask

  task automatic tick();
    drive_samples();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic set_samples(input int s0, input int s1, input int s2, input int s3);
    smp[0] = s0;
    smp[1] = s1;
    smp[2] = s2;
    smp[3] = s3;
  endtask

  task automatic config_ch(input int th, input int g, input int lk, input int md, input int rf);
    thresh        = (AW-1)'(th);
    gain_shift    = 4'(g);
    leak_shift    = 4'(lk);
    reset_mode    = md[0];
    refrac_cycles = RW'(rf);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    enable     = 1'b0;
    samp_valid = 1'b0;
    samp_data  = '0;
    ev_ready   = 1'b0;
    ovf_clr    = 1'b0;
    config_ch(0, 0, 0, 0, 0);
    set_samples(0, 0, 0, 0);
    model_reset();
    #12;
    check_outputs();
    rst_n = 1'b1;

    // Basic fire, zero mode
    enable     = 1'b1;
    samp_valid = 1'b1;
    config_ch(1000, 0, 0, 0, 0);
    set_samples(300, 0, 0, 0);
    repeat (3) tick();
    chk("basic_nofire", 64'(spike_vec), 64'd0);
    tick();
    chk("basic_spike", 64'(spike_vec), 64'd1);
    chk("basic_time", 64'(ev_time), 64'd3);
    samp_valid = 1'b0;
    ev_ready   = 1'b1;
    tick();

    // Subtract mode
    samp_valid = 1'b1;
    config_ch(1000, 0, 0, 1, 0);
    repeat (3) tick();
    tick();
    chk("sub_spike", 64'(spike_vec), 64'd1);
    set_samples(0, 0, 0, 0);
    tick();

    // Refractory on ch1
    config_ch(1000, 0, 0, 0, 2);
    set_samples(0, 600, 0, 0);
    tick();
    tick();
    chk("refrac_fire1", 64'(spike_vec[1]), 64'd1);
    tick();
    tick();
    tick();
    chk("refrac_quiet", 64'(spike_vec[1]), 64'd0);
    tick();
    chk("refrac_fire2", 64'(spike_vec[1]), 64'd1);

    // Leak on ch2 never reaches threshold
    config_ch(1000, 0, 1, 0, 0);
    set_samples(0, 0, 100, 0);
    begin
      int seen;
      seen = 0;
      repeat (50) begin
        tick();
        seen |= int'(spike_vec[2]);
      end
      chk("leak_nofire", 64'(seen), 64'd0);
    end

    // Saturation on ch3
    config_ch(524287, 8, 0, 0, 0);
    set_samples(0, 0, 0, 2047);
    repeat (3) begin
      tick();
      chk("sat_pos_nofire", 64'(spike_vec[3]), 64'd0);
    end
    set_samples(0, 0, 0, -2048);
    config_ch(1000, 8, 0, 0, 0);
    repeat (4) tick();

    // FIFO overflow and drain
    samp_valid = 1'b0;
    ev_ready   = 1'b1;
    repeat (10) tick();
    pulse_reset();
    ev_ready   = 1'b0;
    samp_valid = 1'b1;
    config_ch(0, 0, 0, 0, 0);
    set_samples(100, 100, 100, 100);
    repeat (10) tick();
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_head_time", 64'(ev_time), 64'd0);
    samp_valid = 1'b0;
    ev_ready   = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_time", 64'(ev_time), 64'(i));
      chk("drain_mask", 64'(ev_mask), 64'hF);
      tick();
    end
    chk("drain_empty", 64'(ev_valid), 64'd0);
    chk("ovf_sticky", 64'(overflow), 64'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared", 64'(overflow), 64'd0);

    // Reset mid-run with three queued events
    ev_ready   = 1'b0;
    samp_valid = 1'b1;
    config_ch(50, 0, 0, 1, 0);
    repeat (3) tick();
    chk("pre_rst_spike", 64'(spike_vec), 64'hF);
    rst_n = 1'b0;
    #1;
    chk("rst_ev_valid", 64'(ev_valid), 64'd0);
    chk("rst_spike", 64'(spike_vec), 64'd0);
    model_reset();
    #1;
    rst_n = 1'b1;
    tick();
    chk("rst_time", 64'(ev_time), 64'd0);
    chk("rst_valid", 64'(ev_valid), 64'd1);

    // Randomized traffic
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc % 64 == 0) begin
        config_ch(int'($urandom_range(0, 20000)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 4)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)));
      end
      enable     = ($urandom_range(0, 7) != 0);
      samp_valid = ($urandom_range(0, 3) != 0);
      ev_ready   = ($urandom_range(0, 2) == 0);
      ovf_clr    = ($urandom_range(0, 31) == 0);
      for (int c = 0; c < NCH; c++) begin
        smp[c] = int'($urandom_range(0, 4095)) - 2048;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
